// File: rtl/sw_debounce.sv
// Purpose : slide-switch conditioner - 2-flop sync, per-bit debounce, rise/fall event report.
// Latency : raw step -> sw_stable after DEBOUNCE_CYCLES+2 clk edges (sync 2 + count).
// Backpressure: events accumulate in chg_rise/chg_fall until chg_ack; nothing is dropped.
//
// Ports:
//   clk        system clock, rising edge
//   reset      synchronous, active-low
//   sw_raw     asynchronous switch pins
//   sw_stable  debounced switch word
//   chg_valid  at least one stable bit changed since the last accepted event
//   chg_rise   bits that went 0->1 while the event is pending
//   chg_fall   bits that went 1->0 while the event is pending
//   chg_ack    consumer accepts the pending event (ignored while chg_valid=0)
module sw_debounce #(
    parameter int WIDTH           = 8,
    parameter int DEBOUNCE_CYCLES = 250000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] sw_raw,
    output logic [WIDTH-1:0] sw_stable,
    output logic             chg_valid,
    output logic [WIDTH-1:0] chg_rise,
    output logic [WIDTH-1:0] chg_fall,
    input  logic             chg_ack
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    // Per-bit debounce state; it is a pure function of s2 vs sw_stable, so
    // no separate state flop is kept.
    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_COUNT = 1'b1;

    logic [WIDTH-1:0] s1;
    logic [WIDTH-1:0] s2;
    logic [WIDTH-1:0] state;
    logic [WIDTH-1:0] upd;
    logic [WIDTH-1:0] rise_new;
    logic [WIDTH-1:0] fall_new;
    logic [CNT_W-1:0] cnt [WIDTH];

    always_comb begin
        state = '0;
        upd   = '0;
        for (int i = 0; i < WIDTH; i++) begin
            state[i] = (s2[i] != sw_stable[i]) ? ST_COUNT : ST_IDLE;
            // A bit fires on the cycle its count has already seen
            // DEBOUNCE_CYCLES-1 differing cycles, i.e. the DEBOUNCE_CYCLES-th one.
            upd[i]   = (state[i] == ST_COUNT) && (cnt[i] == CNT_MAX);
        end
    end

    // Firing bits take the synced value, which is always the inverse of the
    // current stable value, so the event polarity comes straight from s2.
    assign rise_new = upd & s2;
    assign fall_new = upd & ~s2;

    // Synchroniser, stable word and counters.
    always_ff @(posedge clk) begin
        if (!reset) begin
            s1        <= '0;
            s2        <= '0;
            sw_stable <= '0;
            for (int i = 0; i < WIDTH; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            s1        <= sw_raw;
            s2        <= s1;
            // Firing bits always differ from stable, so toggling them adopts s2.
            sw_stable <= sw_stable ^ upd;
            for (int i = 0; i < WIDTH; i++) begin
                // Matching input (or a bounce back) restarts the count; the
                // counter also restarts after a fire so it never passes CNT_MAX.
                if ((state[i] == ST_IDLE) || upd[i]) begin
                    cnt[i] <= '0;
                end else begin
                    cnt[i] <= cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    // Event register. While an event is pending and unacknowledged, new
    // edges are OR-ed in; an ack that coincides with new edges hands those
    // edges over as a fresh event instead of dropping them.
    always_ff @(posedge clk) begin
        if (!reset) begin
            chg_valid <= 1'b0;
            chg_rise  <= '0;
            chg_fall  <= '0;
        end else if (!chg_valid) begin
            chg_valid <= |upd;
            chg_rise  <= rise_new;
            chg_fall  <= fall_new;
        end else if (!chg_ack) begin
            chg_rise  <= chg_rise | rise_new;
            chg_fall  <= chg_fall | fall_new;
        end else begin
            chg_valid <= |upd;
            chg_rise  <= rise_new;
            chg_fall  <= fall_new;
        end
    end

endmodule
